// File: rtl/parse_unit_if.sv
// Handshake bundle between Fetch, parse_unit and Decode.
// The slave modport is the parse unit's view; master is the Fetch/Decode side.
interface parse_unit_if;
    logic        flushBack_i;
    logic        enable_i;
    logic [59:0] data_i;
    logic [15:0] pc_i;
    logic        stall_o;
    logic        valid_o;
    logic        ready_i;
    logic [29:0] instr_o;
    logic        format_o;
    logic        branch_o;
    logic [6:0]  opcode_o;
    logic [4:0]  regA_o;
    logic [4:0]  regB_o;
    logic [15:0] imm_o;
    logic [15:0] pc_o;
    logic        slot_o;
    logic        overflow_o;

    modport slave (
        input  flushBack_i, enable_i, data_i, pc_i, ready_i,
        output stall_o, valid_o, instr_o, format_o, branch_o, opcode_o,
               regA_o, regB_o, imm_o, pc_o, slot_o, overflow_o
    );

    modport master (
        output flushBack_i, enable_i, data_i, pc_i, ready_i,
        input  stall_o, valid_o, instr_o, format_o, branch_o, opcode_o,
               regA_o, regB_o, imm_o, pc_o, slot_o, overflow_o
    );
endinterface

// File: rtl/parse_unit.sv
// Parse stage: splits 60-bit fetch bundles, drops NOPs, queues instructions in an
// in-order FIFO and issues one per cycle to decode over valid/ready.
module parse_unit #(
    parameter int DEPTH = 8
) (
    input  logic         clock_i,
    input  logic         reset_i,
    parse_unit_if.slave  bus
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(DEPTH);
    localparam int PW1 = PW + 1;

    typedef struct packed {
        logic [29:0] instr;
        logic [15:0] pc;
        logic        slot;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    entry_t        entry_p1;
    logic          vld_p1;
    logic          ovf;

    logic [29:0]   first_p0;
    logic [29:0]   second_p0;
    logic          room_p0;
    logic          capture_p0;
    logic          push_a_p0;
    logic          push_b_p0;
    logic [1:0]    n_push_p0;
    logic [PW-1:0] wr_b_p0;
    logic          pop_p0;

    // Modulo-DEPTH pointer advance; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW1-1:0] s;
        s = {1'b0, p} + PW1'(n);
        if (s >= PW1'(DEPTH))
            s = s - PW1'(DEPTH);
        return s[PW-1:0];
    endfunction

    assign first_p0   = bus.data_i[59:30];
    assign second_p0  = bus.data_i[29:0];
    assign room_p0    = count <= CW'(DEPTH - 2);
    assign capture_p0 = bus.enable_i && !bus.flushBack_i && room_p0;
    assign push_a_p0  = capture_p0 && (first_p0[27:21] != 7'd0);
    assign push_b_p0  = capture_p0 && (second_p0[27:21] != 7'd0);
    assign n_push_p0  = {1'b0, push_a_p0} + {1'b0, push_b_p0};
    assign wr_b_p0    = push_a_p0 ? ptr_add(wr_ptr, 2'd1) : wr_ptr;
    // Pop decision uses the pre-edge count, so a bundle captured this edge issues next edge.
    assign pop_p0     = !bus.flushBack_i && (!vld_p1 || bus.ready_i) && (count != '0);

    always_ff @(posedge clock_i) begin
        if (push_a_p0)
            mem[wr_ptr] <= '{instr: first_p0, pc: bus.pc_i, slot: 1'b0};
        if (push_b_p0)
            mem[wr_b_p0] <= '{instr: second_p0, pc: bus.pc_i, slot: 1'b1};
    end

    // ---- p0 -> p1: FIFO bookkeeping and output register ----
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            vld_p1   <= 1'b0;
            entry_p1 <= '0;
            ovf      <= 1'b0;
        end else if (bus.flushBack_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            wr_ptr <= ptr_add(wr_ptr, n_push_p0);
            if (pop_p0) begin
                rd_ptr   <= ptr_add(rd_ptr, 2'd1);
                entry_p1 <= mem[rd_ptr];
                vld_p1   <= 1'b1;
            end else if (vld_p1 && bus.ready_i) begin
                vld_p1 <= 1'b0;
            end
            count <= count + CW'(n_push_p0) - CW'(pop_p0);
            if (bus.enable_i && !room_p0)
                ovf <= 1'b1;
        end
    end

    // Stall leaves room for the one bundle Fetch already has in flight.
    assign bus.stall_o    = count > CW'(DEPTH - 4);
    assign bus.valid_o    = vld_p1;
    assign bus.instr_o    = entry_p1.instr;
    assign bus.format_o   = entry_p1.instr[29];
    assign bus.branch_o   = entry_p1.instr[28];
    assign bus.opcode_o   = entry_p1.instr[27:21];
    assign bus.regA_o     = entry_p1.instr[20:16];
    assign bus.regB_o     = entry_p1.instr[15:11];
    assign bus.imm_o      = entry_p1.instr[15:0];
    assign bus.pc_o       = entry_p1.pc;
    assign bus.slot_o     = entry_p1.slot;
    assign bus.overflow_o = ovf;
endmodule
